mem_port_arbiter: RTL and testbench

//  Shares the single port of the 64-word main memory (incl. GPIO_OUT 0x3e / GPIO_IN 0x3f)

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU and a host/debug loader.
// Round-robin per cycle, with a bounded host lock for back-to-back bursts.
module mem_port_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dina,
   input  logic [DATA_W-1:0] mem_douta
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             rr_last_q, rr_last_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;

   logic cpu_win;
   logic host_win;
   logic locked;
   logic lock_exit;
   logic hold;
   logic rr_eff;

   // Winner selection: a live lock keeps the host, otherwise round-robin.
   always_comb begin
      cpu_win   = 1'b0;
      host_win  = 1'b0;
      locked    = (state_q == ST_LOCKED);
      lock_exit = !host_lock || !host_req ||
                  ((lock_cnt_q == CNT_MAX) && cpu_req);
      hold      = locked && !lock_exit;
      rr_eff    = locked ? 1'b1 : rr_last_q;
      if (rst) begin
         cpu_win  = 1'b0;
         host_win = 1'b0;
      end else if (hold) begin
         host_win = 1'b1;
      end else if (cpu_req && (!host_req || rr_eff)) begin
         cpu_win = 1'b1;
      end else if (host_req) begin
         host_win = 1'b1;
      end
   end

   // Next-state for lock FSM, round-robin pointer and read-return tracking.
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      lock_cnt_d = lock_cnt_q;
      rd_pend_d  = (cpu_win && !cpu_we) || (host_win && !host_we);
      rd_owner_d = host_win;
      if (hold) begin
         rr_last_d = 1'b1;
         if (lock_cnt_q != CNT_MAX)
            lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
         state_d    = ST_ARB;
         lock_cnt_d = '0;
         if (cpu_win)
            rr_last_d = 1'b0;
         if (host_win) begin
            rr_last_d = 1'b1;
            if (host_lock) begin
               state_d    = ST_LOCKED;
               lock_cnt_d = CNT_W'(1);
            end
         end
      end
   end

   // State registers with synchronous reset; host is "last" so CPU wins first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ARB;
         rr_last_q  <= 1'b1;
         lock_cnt_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Memory port mux; idle cycles present a harmless read of address 0.
   always_comb begin
      mem_wea   = 1'b0;
      mem_addra = '0;
      mem_dina  = '0;
      if (cpu_win) begin
         mem_wea   = cpu_we;
         mem_addra = cpu_addr;
         mem_dina  = cpu_wdata;
      end else if (host_win) begin
         mem_wea   = host_we;
         mem_addra = host_addr;
         mem_dina  = host_wdata;
      end
   end

   assign cpu_gnt     = cpu_win;
   assign host_gnt    = host_win;
   assign cpu_rvalid  = rd_pend_q && !rd_owner_q && !rst;
   assign host_rvalid = rd_pend_q && rd_owner_q && !rst;
   assign cpu_rdata   = mem_douta;
   assign host_rdata  = mem_douta;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word memory.
// MAX_LOCK is reduced to 4 so lock expiry is reachable in a short burst.
module tb_mem_port_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          host_req, host_we, host_lock;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_wea;
   logic [AW-1:0] mem_addra;
   logic [DW-1:0] mem_dina;
   logic [DW-1:0] mem_douta;

   logic [DW-1:0] mem [0:63];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MAX_LOCK(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_lock  (host_lock),
      .host_gnt   (host_gnt),
      .host_rvalid(host_rvalid),
      .host_rdata (host_rdata),
      .mem_wea    (mem_wea),
      .mem_addra  (mem_addra),
      .mem_dina   (mem_dina),
      .mem_douta  (mem_douta)
   );

   always @(posedge clk) begin
      if (mem_wea) mem[mem_addra] <= mem_dina;
      mem_douta <= mem[mem_addra];
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [42:0] idle_v;
   int k;
   logic exp_h;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[5] = 32'hA5A5_0005;
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      host_lock = 0;

      // reset gating: request during reset gets nothing
      cpu_req = 1; cpu_addr = 6'd5;
      mid();
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_addra", mem_addra, 0);
      chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
      tick(); tick();

      // 1: single CPU read of addr 5
      rst = 0;
      mid();
      chk("t1_cpu_gnt", cpu_gnt, 1);
      chk("t1_host_gnt", host_gnt, 0);
      chk("t1_addra", mem_addra, 5);
      tick();
      cpu_req = 0;
      mid();
      chk("t1_rvalid", cpu_rvalid, 1);
      chk("t1_rdata", cpu_rdata, 32'hA5A5_0005);
      chk("t1_host_rvalid", host_rvalid, 0);
      tick();

      // 2: both request, no lock -> alternate starting with CPU
      rst = 1;
      tick();
      rst = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 6'd1;
      host_req = 1; host_we = 0; host_addr = 6'd2;
      for (int i = 0; i < 6; i++) begin
         mid();
         chk("t2_cpu_gnt", cpu_gnt, (i % 2) == 0);
         chk("t2_host_gnt", host_gnt, (i % 2) == 1);
         if (i > 0) begin
            chk("t2_cpu_rv", cpu_rvalid, ((i - 1) % 2) == 0);
            chk("t2_host_rv", host_rvalid, ((i - 1) % 2) == 1);
         end
         tick();
      end
      cpu_req = 0; host_req = 0;
      mid();
      chk("t2_last_rv", host_rvalid, 1);
      tick();

      // 3: host locked burst vs. persistent CPU, MAX_LOCK=4
      cpu_req = 1; cpu_addr = 6'd9;
      mid();
      chk("t3_pre_gnt", cpu_gnt, 1);
      tick();
      cpu_addr = 6'd10;
      host_req = 1; host_we = 1; host_lock = 1;
      k = 0;
      for (int c = 0; c < 9; c++) begin
         host_addr = AW'(k);
         host_wdata = 32'hB000_0000 | k;
         mid();
         exp_h = (c != 4);
         chk("t3_host_gnt", host_gnt, exp_h);
         chk("t3_cpu_gnt", cpu_gnt, !exp_h);
         chk("t3_wea", mem_wea, exp_h);
         if (exp_h) k++;
         tick();
      end
      host_req = 0; host_we = 0; host_lock = 0;
      mid();
      chk("t3_release", cpu_gnt, 1);
      tick();
      cpu_req = 0;
      for (int i = 0; i < 8; i++)
         chk("t3_mem", mem[i], 32'hB000_0000 | i);

      // 4: host writes GPIO_OUT, CPU reads it back
      host_req = 1; host_we = 1; host_addr = 6'h3e;
      host_wdata = 32'h0000_07FF;
      mid();
      chk("t4_host_gnt", host_gnt, 1);
      chk("t4_wea_w", mem_wea, 1);
      chk("t4_addra", mem_addra, 6'h3e);
      tick();
      host_req = 0; host_we = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 6'h3e;
      mid();
      chk("t4_cpu_gnt", cpu_gnt, 1);
      chk("t4_wea_r", mem_wea, 0);
      tick();
      cpu_req = 0;
      mid();
      chk("t4_rvalid", cpu_rvalid, 1);
      chk("t4_rdata", cpu_rdata, 32'h0000_07FF);
      chk("t4_wea_idle", mem_wea, 0);
      tick();

      // 5: reset while LOCKED with a host read in flight
      host_req = 1; host_we = 0; host_addr = 6'd5; host_lock = 1;
      mid();
      chk("t5_lock_gnt", host_gnt, 1);
      tick();
      host_addr = 6'd6;
      cpu_req = 1; cpu_we = 0; cpu_addr = 6'd7;
      mid();
      chk("t5_locked_h", host_gnt, 1);
      chk("t5_locked_c", cpu_gnt, 0);
      tick();
      rst = 1;
      mid();
      chk("t5_rst_rv", host_rvalid, 0);
      chk("t5_rst_gnt", {cpu_gnt, host_gnt}, 0);
      tick();
      rst = 0;
      mid();
      chk("t5_post_cpu", cpu_gnt, 1);
      chk("t5_post_host", host_gnt, 0);
      chk("t5_post_rv", host_rvalid, 0);
      tick();
      mid();
      chk("t5_next_host", host_gnt, 1);
      chk("t5_next_rv", cpu_rvalid, 1);
      tick();
      cpu_req = 0; host_req = 0; host_lock = 0;
      mid();
      tick();

      // 6: idle for 20 cycles
      for (int i = 0; i < 20; i++) begin
         mid();
         idle_v = {mem_wea, mem_addra, mem_dina, cpu_gnt, host_gnt,
                   cpu_rvalid, host_rvalid};
         chk("t6_idle", idle_v, 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
